// File: rtl/seven_segment_mux_display.sv
// Time-multiplexed common-anode seven-segment driver with shadow-loaded symbols,
// per-digit decimal points, PWM brightness and a frame-complete pulse.
module seven_segment_mux_display #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned COUNT_PERIOD = 100000,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    load_in,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [BRIGHT_W-1:0]     brightness_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int unsigned CNT_W  = $clog2(COUNT_PERIOD);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned CODE_W = 5;
  // Holds (2^BRIGHT_W) * COUNT_PERIOD without overflow.
  localparam int unsigned PROD_W = BRIGHT_W + $clog2(COUNT_PERIOD + 1);

  localparam logic [0:0] LOADING = 1'b0;
  localparam logic [0:0] RUN     = 1'b1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PROD_W-1:0] PERIOD_P = PROD_W'(COUNT_PERIOD);

  logic [0:0]               state, state_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic [IDX_W-1:0]         idx, idx_nx;
  logic [CODE_W*NUM_DIGITS-1:0] codes_sh;
  logic [NUM_DIGITS-1:0]    dp_sh;
  logic [BRIGHT_W-1:0]      bright_sh;

  logic [NUM_DIGITS-1:0]    an_nx;
  logic [6:0]               cat_nx;
  logic                     dp_nx;
  logic                     frame_nx;

  logic [PROD_W-1:0]        on_prod;
  logic [PROD_W-1:0]        on_cycles;
  logic                     lit;
  logic [CODE_W-1:0]        cur_code;

  // Active-low glyph lookup, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'b1000000;
      5'd1:    seg = 7'b1111001;
      5'd2:    seg = 7'b0100100;
      5'd3:    seg = 7'b0110000;
      5'd4:    seg = 7'b0011001;
      5'd5:    seg = 7'b0010010;
      5'd6:    seg = 7'b0000010;
      5'd7:    seg = 7'b1111000;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0010000;
      5'd10:   seg = 7'b0001000;
      5'd11:   seg = 7'b0000011;
      5'd12:   seg = 7'b1000110;
      5'd13:   seg = 7'b0100001;
      5'd14:   seg = 7'b0000110;
      5'd15:   seg = 7'b0001110;
      5'd16:   seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Shadow registers; a held load strobe reloads every cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      codes_sh  <= {NUM_DIGITS{CODE_BLANK}};
      dp_sh     <= '0;
      bright_sh <= '1;
    end else if (load_in) begin
      codes_sh  <= digits_in;
      dp_sh     <= dp_in;
      bright_sh <= brightness_in;
    end
  end

  // PWM on-window length within each digit slot, never shorter than one cycle.
  always_comb begin
    on_prod   = (PROD_W'(bright_sh) + PROD_W'(1)) * PERIOD_P;
    on_cycles = on_prod >> BRIGHT_W;
    if (on_cycles == '0) begin
      on_cycles = PROD_W'(1);
    end
  end

  assign lit      = (PROD_W'(cnt) < on_cycles);
  assign cur_code = codes_sh[CODE_W*idx +: CODE_W];

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    an_nx    = '0;
    cat_nx   = SEG_DASH;
    dp_nx    = 1'b1;
    frame_nx = 1'b0;
    case (state)
      LOADING: begin
        if (load_in) begin
          state_nx = RUN;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          frame_nx = (idx == IDX_LAST);
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
        // Glyph and anode are chosen together so they switch on the same edge.
        if (lit) begin
          an_nx  = ~(NUM_DIGITS'(1) << idx);
          cat_nx = seg_decode(cur_code);
          dp_nx  = ~dp_sh[idx];
        end else begin
          an_nx  = '1;
          cat_nx = SEG_BLANK;
          dp_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = LOADING;
      end
    endcase
  end

  // State, scan position and registered pin outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= LOADING;
      cnt            <= '0;
      idx            <= '0;
      an_out         <= '0;
      cat_out        <= SEG_DASH;
      dp_out         <= 1'b1;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      idx            <= idx_nx;
      an_out         <= an_nx;
      cat_out        <= cat_nx;
      dp_out         <= dp_nx;
      frame_done_out <= frame_nx;
    end
  end

endmodule
